// File: rtl/dsp_file_arbiter.sv
// dsp_file_arbiter: round-robin arbiter that serialises equation-engine file
// transactions onto the single DSP file-I/O port.
module dsp_file_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned dw      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic [NREQ-1:0]      req_read,
  input  logic [NREQ-1:0]      req_write,
  input  logic [8*NREQ-1:0]    req_num,
  input  logic [dw*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_error,
  output logic [dw-1:0]        req_rdata,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [7:0]           file_num,
  output logic                 file_read,
  output logic                 file_write,
  output logic [dw-1:0]        file_write_data,
  input  logic [dw-1:0]        file_read_data,
  input  logic                 file_active
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    WAIT_ACTIVE = 3'd2,
    WAIT_DONE   = 3'd3,
    ACK         = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   sel, cand;
  logic            found;
  logic            wr_q, wr_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      num_d;
  logic [dw-1:0]   wdata_d, rdata_d;
  logic [NREQ-1:0] pend, onehot_d;
  logic [7:0]      sel_num;
  logic [dw-1:0]   sel_wdata;

  assign pend      = req_read | req_write;
  assign sel_num   = req_num[32'(sel)*8 +: 8];
  assign sel_wdata = req_wdata[32'(sel)*dw +: dw];
  assign onehot_d  = NREQ'(1) << idx_d;

  // Round-robin pick: first pending index above the last grant, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(last_q) + k) % NREQ);
      if (!found && pend[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state and datapath decisions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    wr_d    = wr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    num_d   = file_num;
    wdata_d = file_write_data;
    rdata_d = req_rdata;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        cnt_d = '0;
        if (found) begin
          idx_d   = sel;
          wr_d    = req_write[sel];
          num_d   = sel_num;
          wdata_d = sel_wdata;
          if (req_read[sel] && req_write[sel]) begin
            err_d   = 1'b1;
            state_d = ACK;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_ACTIVE;
      end
      WAIT_ACTIVE: begin
        if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (file_active) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // Completion wins over a timeout landing in the same cycle.
        if (!file_active) begin
          if (!wr_q) rdata_d = file_read_data;
          state_d = ACK;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACK: begin
        last_d  = idx_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, the latter decoded from the next state.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      last_q          <= IDX_LAST;
      wr_q            <= 1'b0;
      err_q           <= 1'b0;
      cnt_q           <= '0;
      grant           <= '0;
      busy            <= 1'b0;
      file_read       <= 1'b0;
      file_write      <= 1'b0;
      req_ack         <= '0;
      req_error       <= '0;
      file_num        <= '0;
      file_write_data <= '0;
      req_rdata       <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      last_q          <= last_d;
      wr_q            <= wr_d;
      err_q           <= err_d;
      cnt_q           <= cnt_d;
      grant           <= (state_d != IDLE) ? onehot_d : '0;
      busy            <= (state_d != IDLE);
      file_read       <= (state_d == ISSUE) && !wr_d;
      file_write      <= (state_d == ISSUE) && wr_d;
      req_ack         <= (state_d == ACK) ? onehot_d : '0;
      req_error       <= (state_d == ACK && err_d) ? onehot_d : '0;
      file_num        <= num_d;
      file_write_data <= wdata_d;
      req_rdata       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dsp_file_arbiter.sv
// tb_dsp_file_arbiter: transaction-level reference model of the file-port
// arbiter, checked against the DUT every cycle, plus directed scenarios.
module tb_dsp_file_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned TMO  = 16;

  logic                 wb_clk = 1'b0;
  logic                 wb_rst_n = 1'b0;
  logic [NREQ-1:0]      req_read = '0;
  logic [NREQ-1:0]      req_write = '0;
  logic [8*NREQ-1:0]    req_num = '0;
  logic [DW*NREQ-1:0]   req_wdata = '0;
  logic [NREQ-1:0]      req_ack, req_error, grant;
  logic [DW-1:0]        req_rdata;
  logic                 busy;
  logic [7:0]           file_num;
  logic                 file_read, file_write;
  logic [DW-1:0]        file_write_data;
  logic [DW-1:0]        file_read_data = '0;
  logic                 file_active = 1'b0;

  dsp_file_arbiter #(.NREQ(NREQ), .dw(DW), .TIMEOUT(TMO)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .req_read(req_read), .req_write(req_write), .req_num(req_num), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_error(req_error), .req_rdata(req_rdata),
    .grant(grant), .busy(busy), .file_num(file_num),
    .file_read(file_read), .file_write(file_write), .file_write_data(file_write_data),
    .file_read_data(file_read_data), .file_active(file_active)
  );

  always #5 wb_clk = ~wb_clk;

  longint cyc = 0;
  always @(posedge wb_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Model: one transaction record (grant cycle .. ack cycle) plus latched port values.
  longint        m_g = -1, m_ack = -1;
  longint        m_idle_from = longint'(1) << 40;
  longint        fa_from = -1, fa_to = -2;
  int            m_owner = 0;
  int            m_last = NREQ - 1;
  bit            m_isrd = 0, m_iswr = 0, m_err = 0;
  logic [7:0]    m_num_new = '0, e_num = '0;
  logic [DW-1:0] m_wd_new = '0, e_wd = '0, m_rd_new = '0, e_rdata = '0;
  bit            use_fix = 0;
  int            fix_d = 0, fix_l = 1;
  logic [DW-1:0] fix_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Compare phase: advance to the sampling edge, check every output.
  task automatic pre();
    logic [NREQ-1:0] one, eg;
    bit in_tx;
    @(negedge wb_clk);
    if (cyc == m_g) begin e_num = m_num_new; e_wd = m_wd_new; end
    if (cyc == m_ack && m_isrd && !m_err) e_rdata = m_rd_new;
    one   = NREQ'(1) << m_owner;
    in_tx = (m_g >= 0) && (cyc >= m_g) && (cyc <= m_ack);
    eg    = in_tx ? one : '0;
    chk("grant", 64'(grant), 64'(eg));
    chk("busy", 64'(busy), 64'(in_tx));
    chk("file_read", 64'(file_read), 64'(cyc == m_g && m_isrd));
    chk("file_write", 64'(file_write), 64'(cyc == m_g && m_iswr));
    chk("req_ack", 64'(req_ack), (m_g >= 0 && cyc == m_ack) ? 64'(one) : 64'd0);
    chk("req_error", 64'(req_error), (m_g >= 0 && cyc == m_ack && m_err) ? 64'(one) : 64'd0);
    chk("file_num", 64'(file_num), 64'(e_num));
    chk("file_wdata", 64'(file_write_data), 64'(e_wd));
    chk("req_rdata", 64'(req_rdata), 64'(e_rdata));
    if (m_g >= 0 && cyc == m_ack) begin
      req_read[m_owner]  = 1'b0;
      req_write[m_owner] = 1'b0;
      m_last = m_owner;
    end
    file_active = (cyc >= fa_from) && (cyc <= fa_to);
  endtask

  // Decision phase: if idle, model the grant made from the inputs now driven.
  task automatic post();
    logic [NREQ-1:0] pend;
    int sel, d, l;
    logic [DW-1:0] data;
    pend = req_read | req_write;
    if (cyc < m_idle_from || pend == '0) return;
    sel = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (m_last + k) % NREQ;
      if (sel < 0 && pend[j]) sel = j;
    end
    m_owner   = sel;
    m_g       = cyc + 1;
    m_num_new = req_num[8*sel +: 8];
    m_wd_new  = req_wdata[DW*sel +: DW];
    if (req_read[sel] && req_write[sel]) begin
      m_isrd = 0; m_iswr = 0; m_err = 1;
      m_ack  = m_g;
    end else begin
      m_isrd = req_read[sel];
      m_iswr = req_write[sel];
      if (use_fix) begin
        d = fix_d; l = fix_l; data = fix_data;
      end else begin
        d = int'($urandom_range(3));
        l = ($urandom_range(9) == 0) ? 0 : 1 + int'($urandom_range(3));
        data = $urandom;
      end
      file_read_data = data;
      m_rd_new = data;
      if (l > 0 && d + l <= int'(TMO) - 1) begin
        m_err = 0;
        m_ack = m_g + 2 + d + l;
        fa_from = m_g + 1 + d;
        fa_to   = m_g + d + l;
      end else begin
        m_err = 1;
        m_ack = m_g + TMO + 1;
        fa_from = -1;
        fa_to   = -2;
      end
    end
    m_idle_from = m_ack + 1;
  endtask

  task automatic raise(input int i, input bit rd, input bit wr, input logic [7:0] num,
                       input logic [DW-1:0] wd);
    req_read[i]           = rd;
    req_write[i]          = wr;
    req_num[8*i +: 8]     = num;
    req_wdata[DW*i +: DW] = wd;
  endtask

  function automatic bit is_owner(input int i);
    return (m_g >= 0) && (cyc <= m_ack) && (m_owner == i);
  endfunction

  task automatic rand_act();
    for (int i = 0; i < NREQ; i++) begin
      if (is_owner(i)) begin
        if ((req_read[i] || req_write[i]) && $urandom_range(15) == 0) begin
          req_read[i] = 1'b0; req_write[i] = 1'b0;
        end
      end else if (!(req_read[i] || req_write[i])) begin
        if ($urandom_range(3) == 0) begin
          int r;
          r = int'($urandom_range(15));
          raise(i, (r == 0) || (r % 2 == 1), (r == 0) || (r % 2 == 0), 8'($urandom), $urandom);
        end
      end else if ($urandom_range(31) == 0) begin
        req_read[i] = 1'b0; req_write[i] = 1'b0;
      end
    end
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset(input int ncyc);
    wb_rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ack", 64'(req_ack), 64'd0);
    chk("rst_strobe", 64'({file_read, file_write}), 64'd0);
    chk("rst_num", 64'(file_num), 64'd0);
    chk("rst_wdata", 64'(file_write_data), 64'd0);
    chk("rst_rdata", 64'(req_rdata), 64'd0);
    m_g = -1; m_ack = -1; m_idle_from = longint'(1) << 40;
    m_last = NREQ - 1; m_isrd = 0; m_iswr = 0; m_err = 0;
    e_num = '0; e_wd = '0; e_rdata = '0;
    fa_from = -1; fa_to = -2; file_active = 1'b0;
    req_read = '0; req_write = '0;
    repeat (ncyc) pre();
    wb_rst_n = 1'b1;
    m_idle_from = cyc;
  endtask

  task automatic drain(input int max);
    for (int k = 0; k < max; k++) begin
      if ((req_read | req_write) == '0 && cyc >= m_ack) break;
      pre();
      post();
    end
    chk("drain_done", 64'((req_read | req_write) != '0), 64'd0);
  endtask

  initial begin
    longint n, last_strobe;
    int order[$];
    int exp_order[5];
    bit seen;

    // Power-on reset
    repeat (3) pre();
    chk("por_busy", 64'(busy), 64'd0);
    chk("por_grant", 64'(grant), 64'd0);
    wb_rst_n = 1'b1;
    m_idle_from = cyc;

    // Single read from requester 2, minimum latency
    use_fix = 1; fix_d = 0; fix_l = 1; fix_data = 32'hDEADBEEF;
    pre();
    raise(2, 1, 0, 8'h05, 32'h0);
    post();
    n = cyc;
    for (int k = 1; k <= 4; k++) begin
      pre();
      if (cyc == n + 1) begin
        chk("a_strobe", 64'(file_read), 64'd1);
        chk("a_num", 64'(file_num), 64'h05);
        chk("a_grant", 64'(grant), 64'b0100);
      end
      if (cyc == n + 4) begin
        chk("a_ack", 64'(req_ack), 64'b0100);
        chk("a_err", 64'(req_error), 64'd0);
        chk("a_rdata", 64'(req_rdata), 64'hDEADBEEF);
      end
      post();
    end

    // All four requesters writing continuously from reset
    do_reset(2);
    for (int i = 0; i < NREQ; i++) raise(i, 0, 1, 8'(8'h10 + i), $urandom);
    post();
    last_strobe = -1;
    for (int k = 0; k < 60 && order.size() < 5; k++) begin
      pre();
      if (file_write) begin
        order.push_back(oh2i(grant));
        chk("b_num", 64'(file_num), 64'(8'h10 + oh2i(grant)));
        if (last_strobe >= 0) chk("b_gap", 64'(cyc - last_strobe), 64'd5);
        last_strobe = cyc;
      end
      if (order.size() < 5)
        for (int i = 0; i < NREQ; i++)
          if (!is_owner(i) && !(req_read[i] || req_write[i])) raise(i, 0, 1, 8'(8'h10 + i), $urandom);
      post();
    end
    exp_order = '{0, 1, 2, 3, 0};
    chk("b_count", 64'(order.size()), 64'd5);
    for (int k = 0; k < order.size() && k < 5; k++) chk("b_order", 64'(order[k]), 64'(exp_order[k]));
    drain(100);

    // Requester 1 raises both read and write; requester 2 served after it
    fix_data = 32'h12345678;
    pre();
    raise(1, 1, 1, 8'h11, 32'h0);
    raise(2, 1, 0, 8'h22, 32'h0);
    post();
    n = cyc;
    pre();
    chk("c_ack", 64'(req_ack), 64'b0010);
    chk("c_err", 64'(req_error), 64'b0010);
    chk("c_nostrobe", 64'({file_read, file_write}), 64'd0);
    post();
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      pre();
      if (file_read) begin
        chk("c_next_grant", 64'(grant), 64'b0100);
        seen = 1;
      end
      post();
    end
    chk("c_next_seen", 64'(seen), 64'd1);
    drain(50);

    // Timeout: file port never goes active
    fix_l = 0;
    pre();
    raise(0, 1, 0, 8'h33, 32'h0);
    post();
    n = cyc;
    for (int k = 1; k <= 18; k++) begin
      pre();
      if (k == 17) chk("d_no_early_ack", 64'(req_ack), 64'd0);
      if (k == 18) begin
        chk("d_ack", 64'(req_ack), 64'b0001);
        chk("d_err", 64'(req_error), 64'b0001);
        chk("d_rdata", 64'(req_rdata), 64'h12345678);
        raise(3, 0, 1, 8'h44, 32'hCAFE0003);
      end
      post();
    end
    fix_l = 1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      pre();
      if (file_write) begin
        chk("d_next_grant", 64'(grant), 64'b1000);
        seen = 1;
      end
      post();
    end
    chk("d_next_seen", 64'(seen), 64'd1);
    drain(50);

    // Requester 3 drops its request after grant; transaction still completes
    fix_d = 0; fix_l = 3; fix_data = 32'hA5A50001;
    pre();
    raise(3, 1, 0, 8'h55, 32'h0);
    post();
    n = cyc;
    for (int k = 1; k <= 6; k++) begin
      pre();
      if (k == 2) req_read[3] = 1'b0;
      if (k == 6) begin
        chk("e_drop_ack", 64'(req_ack), 64'b1000);
        chk("e_drop_rdata", 64'(req_rdata), 64'hA5A50001);
      end
      post();
    end

    // Reset while in WAIT_DONE, then requester 0 wins first
    fix_l = 5; fix_data = 32'h0BADF00D;
    pre();
    raise(1, 1, 0, 8'h77, 32'h0);
    post();
    pre(); post();
    pre(); post();
    pre();
    chk("e_busy_before_rst", 64'(busy), 64'd1);
    do_reset(3);
    raise(2, 0, 1, 8'h66, 32'h0);
    raise(0, 1, 0, 8'h01, 32'h0);
    fix_l = 1;
    post();
    pre();
    chk("e_first_grant", 64'(grant), 64'b0001);
    post();
    drain(50);

    // Randomised traffic
    use_fix = 0;
    for (int k = 0; k < 3000; k++) begin
      pre();
      rand_act();
      post();
    end
    drain(200);
    repeat (3) begin pre(); post(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
